// File: rtl/dmt_timing_gen_pkg.sv
// Shared types and constants for the DMT timing generator: 720p defaults,
// region encoding and the flag word carried through the DAT_LEAD pipeline.
package dmt_timing_gen_pkg;

    localparam int unsigned DEF_H_W     = 12;
    localparam int unsigned DEF_V_W     = 11;
    localparam int unsigned DEF_720P_HA  = 1280;
    localparam int unsigned DEF_720P_HFP = 110;
    localparam int unsigned DEF_720P_HS  = 40;
    localparam int unsigned DEF_720P_HBP = 220;
    localparam int unsigned DEF_720P_VA  = 720;
    localparam int unsigned DEF_720P_VFP = 5;
    localparam int unsigned DEF_720P_VS  = 5;
    localparam int unsigned DEF_720P_VBP = 20;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_e;

    // Polarity bits are stored relative to the reset polarity so a zeroed
    // pipeline entry decodes to the inactive sync level.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic hpol_x;
        logic vpol_x;
    } vid_flags_t;

    localparam int unsigned FLAGS_W = $bits(vid_flags_t);

    function automatic region_e region_of(input logic [31:0] cnt,
                                          input logic [31:0] a_end,
                                          input logic [31:0] fp_end,
                                          input logic [31:0] sync_end);
        if (cnt < a_end)         return REG_ACTIVE;
        else if (cnt < fp_end)   return REG_FP;
        else if (cnt < sync_end) return REG_SYNC;
        else                     return REG_BP;
    endfunction

endpackage

// File: rtl/vid_delay_line.sv
// Fixed-depth shift register with synchronous reset to zero; depth 0 is a wire.
module vid_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/dmt_timing_gen.sv
// Runtime-reprogrammable DMT timing generator: lead-time pixel request on the
// user side, delayed de/hsync/vsync/data towards the TMDS encoder.
module dmt_timing_gen
    import dmt_timing_gen_pkg::*;
#(
    parameter int unsigned DW       = 24,
    parameter int unsigned H_W      = DEF_H_W,
    parameter int unsigned V_W      = DEF_V_W,
    parameter int unsigned DAT_LEAD = 2,
    parameter int unsigned DEF_HA   = DEF_720P_HA,
    parameter int unsigned DEF_HFP  = DEF_720P_HFP,
    parameter int unsigned DEF_HS   = DEF_720P_HS,
    parameter int unsigned DEF_HBP  = DEF_720P_HBP,
    parameter int unsigned DEF_VA   = DEF_720P_VA,
    parameter int unsigned DEF_VFP  = DEF_720P_VFP,
    parameter int unsigned DEF_VS   = DEF_720P_VS,
    parameter int unsigned DEF_VBP  = DEF_720P_VBP,
    parameter int unsigned DEF_HPOL = 1,
    parameter int unsigned DEF_VPOL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [H_W-1:0] cfg_h_active,
    input  logic [H_W-1:0] cfg_h_fp,
    input  logic [H_W-1:0] cfg_h_sync,
    input  logic [H_W-1:0] cfg_h_bp,
    input  logic [V_W-1:0] cfg_v_active,
    input  logic [V_W-1:0] cfg_v_fp,
    input  logic [V_W-1:0] cfg_v_sync,
    input  logic [V_W-1:0] cfg_v_bp,
    input  logic           cfg_hs_pol,
    input  logic           cfg_vs_pol,
    input  logic           cfg_load,
    output logic           cfg_busy,
    output logic           cfg_err,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           dat_rdy,
    output logic           frame_start,
    input  logic [DW-1:0]  dat_in,
    output logic [DW-1:0]  dat_out,
    output logic           hsync,
    output logic           vsync,
    output logic           de
);

    localparam int unsigned HC_W = H_W + 2;
    localparam int unsigned VC_W = V_W + 2;

    logic [H_W-1:0]  ha_q, hfp_q, hs_q, hbp_q, p_ha, p_hfp, p_hs, p_hbp;
    logic [V_W-1:0]  va_q, vfp_q, vs_q, vbp_q, p_va, p_vfp, p_vs, p_vbp;
    logic            hpol_q, vpol_q, p_hpol, p_vpol;
    logic [HC_W-1:0] hcnt, h_a, h_af, h_afs, h_t;
    logic [VC_W-1:0] vcnt, v_a, v_af, v_afs, v_t;
    region_e         h_reg, v_reg;
    logic            act, wrap, apply_ok, cfg_ok, hpol_eff, vpol_eff;
    vid_flags_t      flags_in, flags_q, flags_dl;
    logic [FLAGS_W-1:0] dl_q;

    // Region boundaries at widened precision so the totals never overflow.
    always_comb begin
        h_a   = HC_W'(ha_q);
        h_af  = h_a + HC_W'(hfp_q);
        h_afs = h_af + HC_W'(hs_q);
        h_t   = h_afs + HC_W'(hbp_q);
        v_a   = VC_W'(va_q);
        v_af  = v_a + VC_W'(vfp_q);
        v_afs = v_af + VC_W'(vs_q);
        v_t   = v_afs + VC_W'(vbp_q);
        h_reg = region_of(32'(hcnt), 32'(h_a), 32'(h_af), 32'(h_afs));
        v_reg = region_of(32'(vcnt), 32'(v_a), 32'(v_af), 32'(v_afs));
        act   = en && (h_reg == REG_ACTIVE) && (v_reg == REG_ACTIVE);
        wrap  = en && (hcnt == h_t - HC_W'(1)) && (vcnt == v_t - VC_W'(1));
        apply_ok = wrap || !en;
        cfg_ok = (cfg_h_active != '0) && (cfg_h_fp != '0) && (cfg_h_sync != '0)
              && (cfg_h_bp != '0) && (cfg_v_active != '0) && (cfg_v_fp != '0)
              && (cfg_v_sync != '0) && (cfg_v_bp != '0);
        flags_in = '{active: act,
                     hs:     en && (h_reg == REG_SYNC),
                     vs:     en && (v_reg == REG_SYNC),
                     hpol_x: hpol_q ^ 1'(DEF_HPOL),
                     vpol_x: vpol_q ^ 1'(DEF_VPOL)};
        flags_dl = vid_flags_t'(dl_q);
        hpol_eff = flags_dl.hpol_x ^ 1'(DEF_HPOL);
        vpol_eff = flags_dl.vpol_x ^ 1'(DEF_VPOL);
    end

    // Counters and the pending/active configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;  vcnt <= '0;
            ha_q <= H_W'(DEF_HA);  hfp_q <= H_W'(DEF_HFP);
            hs_q <= H_W'(DEF_HS);  hbp_q <= H_W'(DEF_HBP);
            va_q <= V_W'(DEF_VA);  vfp_q <= V_W'(DEF_VFP);
            vs_q <= V_W'(DEF_VS);  vbp_q <= V_W'(DEF_VBP);
            hpol_q <= 1'(DEF_HPOL);  vpol_q <= 1'(DEF_VPOL);
            p_ha <= '0;  p_hfp <= '0;  p_hs <= '0;  p_hbp <= '0;
            p_va <= '0;  p_vfp <= '0;  p_vs <= '0;  p_vbp <= '0;
            p_hpol <= 1'b0;  p_vpol <= 1'b0;
            cfg_busy <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (!en) begin
                hcnt <= '0;
                vcnt <= '0;
            end else if (hcnt == h_t - HC_W'(1)) begin
                hcnt <= '0;
                vcnt <= (vcnt == v_t - VC_W'(1)) ? '0 : vcnt + VC_W'(1);
            end else begin
                hcnt <= hcnt + HC_W'(1);
            end

            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load && cfg_ok && apply_ok) begin
                ha_q <= cfg_h_active;  hfp_q <= cfg_h_fp;
                hs_q <= cfg_h_sync;    hbp_q <= cfg_h_bp;
                va_q <= cfg_v_active;  vfp_q <= cfg_v_fp;
                vs_q <= cfg_v_sync;    vbp_q <= cfg_v_bp;
                hpol_q <= cfg_hs_pol;  vpol_q <= cfg_vs_pol;
                cfg_busy <= 1'b0;
            end else if (cfg_load && cfg_ok) begin
                p_ha <= cfg_h_active;  p_hfp <= cfg_h_fp;
                p_hs <= cfg_h_sync;    p_hbp <= cfg_h_bp;
                p_va <= cfg_v_active;  p_vfp <= cfg_v_fp;
                p_vs <= cfg_v_sync;    p_vbp <= cfg_v_bp;
                p_hpol <= cfg_hs_pol;  p_vpol <= cfg_vs_pol;
                cfg_busy <= 1'b1;
            end else if (cfg_busy && apply_ok) begin
                ha_q <= p_ha;  hfp_q <= p_hfp;  hs_q <= p_hs;  hbp_q <= p_hbp;
                va_q <= p_va;  vfp_q <= p_vfp;  vs_q <= p_vs;  vbp_q <= p_vbp;
                hpol_q <= p_hpol;  vpol_q <= p_vpol;
                cfg_busy <= 1'b0;
            end
        end
    end

    // Request stage and video output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_rdy     <= 1'b0;
            frame_start <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            flags_q     <= '0;
            de          <= 1'b0;
            hsync       <= ~1'(DEF_HPOL);
            vsync       <= ~1'(DEF_VPOL);
            dat_out     <= '0;
        end else begin
            dat_rdy     <= act;
            frame_start <= act && (hcnt == '0) && (vcnt == '0);
            hcount      <= act ? H_W'(hcnt) : '0;
            vcount      <= act ? V_W'(vcnt) : '0;
            flags_q     <= flags_in;
            de          <= flags_dl.active;
            hsync       <= flags_dl.hs ? hpol_eff : ~hpol_eff;
            vsync       <= flags_dl.vs ? vpol_eff : ~vpol_eff;
            dat_out     <= flags_dl.active ? dat_in : '0;
        end
    end

    vid_delay_line #(
        .WIDTH (FLAGS_W),
        .DEPTH (DAT_LEAD)
    ) u_flag_dly (
        .clk (clk),
        .rst (rst),
        .d   (flags_q),
        .q   (dl_q)
    );

endmodule

// File: tb/tb_dmt_timing_gen.sv
// Randomised bench for dmt_timing_gen in a small mode, three DAT_LEAD settings
// side by side, against a frame-position reference model.
module tb_dmt_timing_gen;

    localparam int unsigned DW  = 24;
    localparam int unsigned H_W = 12;
    localparam int unsigned V_W = 11;
    localparam int NI = 3;

    logic clk, rst, en, cfg_load, c_hp, c_vp;
    logic [H_W-1:0] c_ha, c_hfp, c_hs, c_hbp;
    logic [V_W-1:0] c_va, c_vfp, c_vs, c_vbp;
    logic [DW-1:0]  dat_in;

    logic           busy_o [NI], err_o [NI], rdy_o [NI], fs_o [NI];
    logic           de_o [NI], hs_o [NI], vs_o [NI];
    logic [H_W-1:0] hc_o [NI];
    logic [V_W-1:0] vc_o [NI];
    logic [DW-1:0]  dout_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 0 : 15;
        dmt_timing_gen #(
            .DW(DW), .H_W(H_W), .V_W(V_W), .DAT_LEAD(L),
            .DEF_HA(8), .DEF_HFP(2), .DEF_HS(2), .DEF_HBP(2),
            .DEF_VA(4), .DEF_VFP(1), .DEF_VS(1), .DEF_VBP(1),
            .DEF_HPOL(1), .DEF_VPOL(1)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en),
            .cfg_h_active(c_ha), .cfg_h_fp(c_hfp), .cfg_h_sync(c_hs), .cfg_h_bp(c_hbp),
            .cfg_v_active(c_va), .cfg_v_fp(c_vfp), .cfg_v_sync(c_vs), .cfg_v_bp(c_vbp),
            .cfg_hs_pol(c_hp), .cfg_vs_pol(c_vp), .cfg_load(cfg_load),
            .cfg_busy(busy_o[g]), .cfg_err(err_o[g]),
            .hcount(hc_o[g]), .vcount(vc_o[g]),
            .dat_rdy(rdy_o[g]), .frame_start(fs_o[g]),
            .dat_in(dat_in), .dat_out(dout_o[g]),
            .hsync(hs_o[g]), .vsync(vs_o[g]), .de(de_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ha, hfp, hs, hbp, va, vfp, vs, vbp; bit hp, vp; } tcfg_t;

    tcfg_t cur, pend;
    bit    busy;
    int    mk;                 // cycles since the start of the current frame
    int    edge_n, rst_edge;
    bit    e_rdy, e_fs, e_err;
    int    e_hc, e_vc;
    logic [DW-1:0] last_din;
    bit    h_rdy [64], h_hl [64], h_vl [64];
    int    n_chk, n_fail;

    bit meas;
    int first_rdy, fs1, fs2, rdy_cnt;
    int first_de [NI];

    function automatic int lead_of(int g);
        return (g == 0) ? 2 : (g == 1) ? 0 : 15;
    endfunction

    function automatic tcfg_t def_cfg();
        tcfg_t c;
        c.ha = 8; c.hfp = 2; c.hs = 2; c.hbp = 2;
        c.va = 4; c.vfp = 1; c.vs = 1; c.vbp = 1;
        c.hp = 1'b1; c.vp = 1'b1;
        return c;
    endfunction

    function automatic tcfg_t in_cfg();
        tcfg_t c;
        c.ha = int'(c_ha); c.hfp = int'(c_hfp); c.hs = int'(c_hs); c.hbp = int'(c_hbp);
        c.va = int'(c_va); c.vfp = int'(c_vfp); c.vs = int'(c_vs); c.vbp = int'(c_vbp);
        c.hp = c_hp; c.vp = c_vp;
        return c;
    endfunction

    // Before the last reset the video outputs sit at the reset (inactive) levels.
    function automatic bit hist_rdy(int idx);
        return (idx <= rst_edge) ? 1'b0 : h_rdy[idx % 64];
    endfunction
    function automatic bit hist_hl(int idx);
        return (idx <= rst_edge) ? 1'b0 : h_hl[idx % 64];
    endfunction
    function automatic bit hist_vl(int idx);
        return (idx <= rst_edge) ? 1'b0 : h_vl[idx % 64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic set_cfg(input int ha, hfp, hs, hbp, va, vfp, vs, vbp, input bit hp, vp);
        c_ha = H_W'(ha); c_hfp = H_W'(hfp); c_hs = H_W'(hs); c_hbp = H_W'(hbp);
        c_va = V_W'(va); c_vfp = V_W'(vfp); c_vs = V_W'(vs); c_vbp = V_W'(vbp);
        c_hp = hp; c_vp = vp;
    endtask

    // Reference: position within the frame drives everything else.
    task automatic model_eval();
        tcfg_t req;
        int ht, vt, h, v;
        bit ok, wrap, act, hsr, vsr;
        edge_n++;
        last_din = dat_in;
        if (rst) begin
            cur = def_cfg(); pend = cur; busy = 1'b0; mk = 0;
            e_rdy = 0; e_fs = 0; e_err = 0; e_hc = 0; e_vc = 0;
            rst_edge = edge_n;
        end else begin
            ht  = cur.ha + cur.hfp + cur.hs + cur.hbp;
            vt  = cur.va + cur.vfp + cur.vs + cur.vbp;
            h   = mk % ht;
            v   = mk / ht;
            act = en && (h < cur.ha) && (v < cur.va);
            hsr = en && (h >= cur.ha + cur.hfp) && (h < cur.ha + cur.hfp + cur.hs);
            vsr = en && (v >= cur.va + cur.vfp) && (v < cur.va + cur.vfp + cur.vs);
            h_rdy[edge_n % 64] = act;
            h_hl[edge_n % 64]  = hsr ? cur.hp : !cur.hp;
            h_vl[edge_n % 64]  = vsr ? cur.vp : !cur.vp;
            e_rdy = act;
            e_fs  = act && (mk == 0);
            e_hc  = act ? h : 0;
            e_vc  = act ? v : 0;
            wrap  = en && (mk == ht * vt - 1);
            req   = in_cfg();
            ok    = req.ha != 0 && req.hfp != 0 && req.hs != 0 && req.hbp != 0 &&
                    req.va != 0 && req.vfp != 0 && req.vs != 0 && req.vbp != 0;
            e_err = cfg_load && !ok;
            if (cfg_load && ok) begin
                if (wrap || !en) begin cur = req; busy = 1'b0; end
                else begin pend = req; busy = 1'b1; end
            end else if (busy && (wrap || !en)) begin
                cur = pend; busy = 1'b0;
            end
            mk = (!en || wrap) ? 0 : mk + 1;
        end
    endtask

    task automatic compare();
        for (int g = 0; g < NI; g++) begin
            int  l   = lead_of(g);
            int  idx = edge_n - l - 1;
            bit  ed  = hist_rdy(idx);
            chk($sformatf("dat_rdy_L%0d", l), 64'(rdy_o[g]), 64'(e_rdy));
            chk($sformatf("frame_start_L%0d", l), 64'(fs_o[g]), 64'(e_fs));
            chk($sformatf("hcount_L%0d", l), 64'(hc_o[g]), 64'(e_hc));
            chk($sformatf("vcount_L%0d", l), 64'(vc_o[g]), 64'(e_vc));
            chk($sformatf("cfg_busy_L%0d", l), 64'(busy_o[g]), 64'(busy));
            chk($sformatf("cfg_err_L%0d", l), 64'(err_o[g]), 64'(e_err));
            chk($sformatf("de_L%0d", l), 64'(de_o[g]), 64'(ed));
            chk($sformatf("hsync_L%0d", l), 64'(hs_o[g]), 64'(hist_hl(idx)));
            chk($sformatf("vsync_L%0d", l), 64'(vs_o[g]), 64'(hist_vl(idx)));
            chk($sformatf("dat_out_L%0d", l), 64'(dout_o[g]), 64'(ed ? last_din : '0));
        end
    endtask

    task automatic cyc();
        dat_in = DW'($urandom);
        model_eval();
        @(posedge clk);
        #1;
        compare();
        if (meas) begin
            if (rdy_o[0] && first_rdy < 0) first_rdy = edge_n;
            for (int g = 0; g < NI; g++)
                if (de_o[g] && first_de[g] < 0) first_de[g] = edge_n;
            if (fs_o[0]) begin
                if (fs1 < 0) fs1 = edge_n;
                else if (fs2 < 0) fs2 = edge_n;
            end
            if (fs1 >= 0 && fs2 < 0 && rdy_o[0]) rdy_cnt++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (mk != target && n < 500) begin
            cyc();
            n++;
        end
        if (mk != target) chk("run_until", 64'(mk), 64'(target));
    endtask

    task automatic start_meas();
        meas = 1'b1; first_rdy = -1; fs1 = -1; fs2 = -1; rdy_cnt = 0;
        for (int g = 0; g < NI; g++) first_de[g] = -1;
    endtask

    task automatic check_lags();
        for (int g = 0; g < NI; g++)
            chk($sformatf("de_lag_L%0d", lead_of(g)), 64'(first_de[g] - first_rdy),
                64'(lead_of(g) + 1));
    endtask

    function automatic int rf(input int hi);
        return ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, hi));
    endfunction

    initial begin
        n_chk = 0; n_fail = 0; edge_n = 0; rst_edge = 0; mk = 0;
        cur = def_cfg(); pend = cur; busy = 1'b0; meas = 1'b0;
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0; dat_in = '0;
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
        run(3);

        // Default small mode: frame period, requests per frame, de lag.
        rst = 1'b0; en = 1'b1;
        start_meas();
        run(230);
        chk("frame_period", 64'(fs2 - fs1), 64'd98);
        chk("rdy_per_frame", 64'(rdy_cnt), 64'd32);
        check_lags();
        meas = 1'b0;

        // Mid-frame reprogram to 6 active columns, applied at the wrap.
        run_until(50);
        set_cfg(6, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
        cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("busy_after_load", 64'(busy_o[0]), 64'd1);
        run(230);

        // Rejected load: zero sync width.
        set_cfg(6, 2, 0, 2, 4, 1, 1, 1, 1'b1, 1'b1);
        cfg_load = 1'b1; cyc(); cfg_load = 1'b0;
        chk("err_pulse", 64'(err_o[0]), 64'd1);
        cyc();
        chk("err_clear", 64'(err_o[0]), 64'd0);
        run(40);

        // Enable drop at column 5 of line 2, then restart.
        run_until(2 * (cur.ha + cur.hfp + cur.hs + cur.hbp) + 5);
        en = 1'b0; cyc();
        chk("rdy_after_drop", 64'(rdy_o[0]), 64'd0);
        run(3);
        chk("de_after_drop", 64'(de_o[0]), 64'd0);
        run(5);
        en = 1'b1; cyc();
        chk("fs_on_reenable", 64'(fs_o[0]), 64'd1);
        chk("hcount_on_reenable", 64'(hc_o[0]), 64'd0);
        run(60);

        // Reset in the middle of a line, then re-measure lead offsets.
        run_until(20);
        rst = 1'b1; cyc();
        chk("rst_rdy", 64'(rdy_o[0]), 64'd0);
        rst = 1'b0;
        start_meas();
        run(40);
        check_lags();
        meas = 1'b0;

        // Random traffic: reloads (some invalid), enable gaps, resets, polarity.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            en       = ($urandom_range(0, 29) != 0);
            cfg_load = ($urandom_range(0, 39) == 0);
            if (cfg_load)
                set_cfg(rf(8), rf(3), rf(3), rf(3), rf(5), rf(2), rf(2), rf(2),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc();
        end
        rst = 1'b0; cfg_load = 1'b0; en = 1'b1;
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
